// File: rtl/op_issue.sv
// op_issue: buffers decoded read/write requests and emits held, NOP-separated op_codes.
module op_issue #(
  parameter int DEPTH = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES = 1,
  parameter logic [3:0] OP_NOP = 4'b0000,
  parameter logic [3:0] OP_WRITE_A = 4'b0001,
  parameter logic [3:0] OP_WRITE_B = 4'b0010,
  parameter logic [3:0] OP_READ_C = 4'b0100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_source,
  output logic [3:0] op_code,
  output logic       op_valid,
  output logic       busy,
  output logic       err
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int MX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [NW-1:0] count;
  logic [CW-1:0] cnt;
  logic [3:0] enc;
  logic legal, accept, push, pop, decide, empty;
  always_comb begin
    legal = req_write ? (req_source == 2'd0 || req_source == 2'd1) : (req_source == 2'd2);
    enc = !req_write ? OP_READ_C : req_source == 2'd0 ? OP_WRITE_A : OP_WRITE_B;
    empty = count == '0;
    accept = req_valid && req_ready;
    push = accept && legal;
    // Points where the FSM may start a new op; with no gap, the last hold cycle is one of them.
    decide = state == IDLE || (state == HOLD && cnt == '0 && GAP_CYCLES == 0) || (state == GAP && cnt == '0);
    pop = decide && !empty;
  end
  assign req_ready = count != NW'(DEPTH) && !rst;
  assign busy = !empty || state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= enc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + NW'(push) - NW'(pop);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_code <= OP_NOP;
      op_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (pop) begin
        op_code <= mem[rptr];
        op_valid <= 1'b1;
        cnt <= CW'(HOLD_CYCLES - 1);
        state <= HOLD;
      end else if (decide) begin
        op_code <= OP_NOP;
        op_valid <= 1'b0;
        cnt <= '0;
        state <= IDLE;
      end else if (state == HOLD && cnt == '0) begin
        op_code <= OP_NOP;
        op_valid <= 1'b0;
        cnt <= CW'(GAP_CYCLES - 1);
        state <= GAP;
      end else if (cnt != '0) cnt <= cnt - CW'(1);
    end
endmodule
